alu_share_arbiter: RTL and testbench

//   Shares one registered 8-bit bitwise/arithmetic unit (AND, OR, ADD, SUB) among
//   NUM_REQ requesters. Requesters win access by round-robin arbitration, then the

---
 rtl/alu_share_arbiter_if.sv | 29 ++
 rtl/alu_share_arbiter.sv | 154 +++++++++++++++
 tb/tb_alu_share_arbiter.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_share_arbiter_if.sv
// Request/response bundle between NUM_REQ clients and the shared ALU arbiter.
// The master side belongs to the clients; the slave side belongs to the arbiter.
interface alu_share_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int IDW     = 2
);

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [2*NUM_REQ-1:0]     req_op;
  logic [WIDTH*NUM_REQ-1:0] req_a;
  logic [WIDTH*NUM_REQ-1:0] req_b;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [IDW-1:0]           rsp_id;
  logic [WIDTH-1:0]         rsp_data;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data
  );

endinterface

// File: rtl/alu_share_arbiter.sv
// One registered AND/OR/ADD/SUB unit time-shared by NUM_REQ clients.
// A round-robin arbiter picks a winner in IDLE; the FSM then runs EXEC and RESP.
module alu_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  alu_share_arbiter_if.slave    bus,
  output logic                  busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_ADD = 2'b10,
    OP_SUB = 2'b11
  } op_e;

  state_e           state_q, state_d;
  logic [IDW-1:0]   last_grant_q, last_grant_d;
  logic [IDW-1:0]   id_q, id_d;
  op_e              op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]   rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;

  logic             grant_valid;
  logic [IDW-1:0]   grant_id;
  op_e              grant_op;
  logic [WIDTH-1:0] grant_a;
  logic [WIDTH-1:0] grant_b;
  logic [NUM_REQ-1:0] req_ready;
  logic [WIDTH-1:0] alu_result;

  // Candidate k of the rotating search: starts just after the last winner.
  function automatic int rr_index(input logic [IDW-1:0] base, input int k);
    return (int'(base) + 1 + k) % NUM_REQ;
  endfunction

  // NOTE: every signal written in an always_comb gets a default at the top,
  // so no path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = '0;
    grant_op    = OP_AND;
    grant_a     = '0;
    grant_b     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!grant_valid && bus.req_valid[rr_index(last_grant_q, k)]) begin
        grant_valid = 1'b1;
        grant_id    = IDW'(rr_index(last_grant_q, k));
        grant_op    = op_e'(bus.req_op[2*rr_index(last_grant_q, k) +: 2]);
        grant_a     = bus.req_a[WIDTH*rr_index(last_grant_q, k) +: WIDTH];
        grant_b     = bus.req_b[WIDTH*rr_index(last_grant_q, k) +: WIDTH];
      end
    end
  end

  // Carry and borrow fall off the top: results wrap modulo 2^WIDTH.
  always_comb begin
    alu_result = '0;
    case (op_q)
      OP_AND:  alu_result = a_q & b_q;
      OP_OR:   alu_result = a_q | b_q;
      OP_ADD:  alu_result = a_q + b_q;
      OP_SUB:  alu_result = a_q - b_q;
      default: alu_result = '0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_data_d   = rsp_data_q;
    req_ready    = '0;

    case (state_q)
      S_IDLE: begin
        if (grant_valid) begin
          req_ready    = NUM_REQ'(1) << grant_id;
          id_d         = grant_id;
          last_grant_d = grant_id;
          op_d         = grant_op;
          a_d          = grant_a;
          b_d          = grant_b;
          state_d      = S_EXEC;
        end
      end
      S_EXEC: begin
        rsp_data_d  = alu_result;
        rsp_id_d    = id_q;
        rsp_valid_d = 1'b1;
        state_d     = S_RESP;
      end
      S_RESP: begin
        // Response fields hold until the consumer takes them; id/data keep their last value.
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its inputs, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      last_grant_q <= IDW'(NUM_REQ - 1);
      id_q         <= '0;
      op_q         <= OP_AND;
      a_q          <= '0;
      b_q          <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_data_q   <= rsp_data_d;
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_data  = rsp_data_q;
  assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: a vector table for single-client ops plus directed
// sequences for rotation, backpressure, reset mid-flight and a withdrawn request.
module tb_alu_share_arbiter;

  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 8;
  localparam int IDW     = 2;

  logic clk;
  logic rst_n;
  logic busy;

  alu_share_arbiter_if #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .IDW(IDW)) bus ();

  alu_share_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [IDW-1:0]   id;
    logic [WIDTH-1:0] data;
  } rsp_t;

  rsp_t sb[$];
  rsp_t mon_e;

  typedef struct {
    int               id;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] exp;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] alu_model(input logic [1:0] op,
                                                 input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
    case (op)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return WIDTH'((a + b) % 256);
      default: return WIDTH'((256 + a - b) % 256);
    endcase
  endfunction

  task automatic set_req(input int i, input logic v, input logic [1:0] op,
                         input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    bus.req_valid[i]           = v;
    bus.req_op[2*i +: 2]       = op;
    bus.req_a[WIDTH*i +: WIDTH] = a;
    bus.req_b[WIDTH*i +: WIDTH] = b;
  endtask

  task automatic push(input int id, input logic [WIDTH-1:0] data);
    rsp_t e;
    e.id   = IDW'(id);
    e.data = data;
    sb.push_back(e);
  endtask

  // Call from a negedge (or shortly after); returns the granted index or -1.
  task automatic wait_grant(output int win);
    win = -1;
    for (int n = 0; n < 20 && win < 0; n++) begin
      if (bus.req_ready != '0) begin
        for (int k = 0; k < NUM_REQ; k++) if (bus.req_ready[k]) win = k;
      end else begin
        @(negedge clk);
      end
    end
    if (win < 0) begin
      checks++;
      errors++;
      $display("FAIL grant_timeout: got no req_ready expected a grant (t=%0t)", $time);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", 32'(busy), 32'd0);
  endtask

  // Scoreboard: compare every accepted response against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected: got id=%0d data=%0h expected no response",
                 bus.rsp_id, bus.rsp_data);
      end else begin
        mon_e = sb.pop_front();
        check("rsp_id", 32'(bus.rsp_id), 32'(mon_e.id));
        check("rsp_data", 32'(bus.rsp_data), 32'(mon_e.data));
      end
    end
  end

  initial begin
    int w;
    int prev_cyc;
    logic [1:0] rr_op;
    logic [WIDTH-1:0] rr_a;
    logic [WIDTH-1:0] rr_b;

    vecs[0] = '{id: 1, op: 2'b10, a: 8'hF0, b: 8'h20, exp: 8'h10};
    vecs[1] = '{id: 0, op: 2'b11, a: 8'h03, b: 8'h05, exp: 8'hFE};
    vecs[2] = '{id: 2, op: 2'b00, a: 8'hCC, b: 8'hAA, exp: 8'h88};
    vecs[3] = '{id: 0, op: 2'b10, a: 8'hFF, b: 8'h01, exp: 8'h00};
    vecs[4] = '{id: 1, op: 2'b11, a: 8'h00, b: 8'h01, exp: 8'hFF};
    vecs[5] = '{id: 3, op: 2'b01, a: 8'hCC, b: 8'hAA, exp: 8'hEE};

    rst_n         = 1'b0;
    bus.req_valid = '0;
    bus.req_op    = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b1;
    #23 rst_n = 1'b1;

    @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("reset_rsp_data", 32'(bus.rsp_data), 32'd0);
    check("reset_rsp_id", 32'(bus.rsp_id), 32'd0);
    check("reset_req_ready", 32'(bus.req_ready), 32'd0);

    // Single-client vectors: grant, 1-cycle latency, result on handshake.
    for (int i = 0; i < 6; i++) begin
      set_req(vecs[i].id, 1'b1, vecs[i].op, vecs[i].a, vecs[i].b);
      #1;
      wait_grant(w);
      check("vec_grant_onehot", 32'(bus.req_ready), 32'(4'b0001 << vecs[i].id));
      if (w >= 0) push(vecs[i].id, vecs[i].exp);
      @(posedge clk); #1;
      set_req(vecs[i].id, 1'b0, 2'b00, 8'h00, 8'h00);
      check("vec_exec_busy", 32'(busy), 32'd1);
      check("vec_exec_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      @(posedge clk); #1;
      check("vec_resp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      @(posedge clk); #1;
      check("vec_back_idle", 32'(busy), 32'd0);
      @(negedge clk);
    end

    // All four continuously valid: rotation 0,1,2,3,0,... every 3 cycles.
    for (int k = 0; k < NUM_REQ; k++)
      set_req(k, 1'b1, 2'(k), 8'(8'h31 * (k + 1)), 8'(8'h17 + k));
    #1;
    prev_cyc = 0;
    for (int g = 0; g < 8; g++) begin
      wait_grant(w);
      check("rr_grant_id", 32'(w), 32'(g % NUM_REQ));
      check("rr_grant_onehot", 32'(bus.req_ready), 32'(4'b0001 << (g % NUM_REQ)));
      if (g > 0) check("rr_spacing", 32'(cyc - prev_cyc), 32'd3);
      prev_cyc = cyc;
      if (w >= 0) begin
        rr_op = bus.req_op[2*w +: 2];
        rr_a  = bus.req_a[WIDTH*w +: WIDTH];
        rr_b  = bus.req_b[WIDTH*w +: WIDTH];
        push(w, alu_model(rr_op, rr_a, rr_b));
      end
      @(negedge clk);
    end
    bus.req_valid = '0;
    wait_idle();
    @(negedge clk);

    // Backpressure: hold RESP for 5 cycles while requester 1 waits.
    bus.rsp_ready = 1'b0;
    set_req(0, 1'b1, 2'b10, 8'h12, 8'h34);
    set_req(1, 1'b1, 2'b11, 8'h50, 8'h08);
    #1;
    wait_grant(w);
    check("bp_grant_id", 32'(w), 32'd0);
    if (w >= 0) push(0, 8'h46);
    @(posedge clk); #1;
    set_req(0, 1'b0, 2'b00, 8'h00, 8'h00);
    @(posedge clk);
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      check("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      check("bp_rsp_data", 32'(bus.rsp_data), 32'h46);
      check("bp_rsp_id", 32'(bus.rsp_id), 32'd0);
      check("bp_busy", 32'(busy), 32'd1);
      check("bp_req_ready", 32'(bus.req_ready), 32'd0);
    end
    @(posedge clk); #1;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_idle", 32'(busy), 32'd0);
    check("bp_release_grant", 32'(bus.req_ready), 32'b0010);
    @(negedge clk);
    wait_grant(w);
    if (w >= 0) push(1, 8'h48);
    @(posedge clk); #1;
    set_req(1, 1'b0, 2'b00, 8'h00, 8'h00);
    wait_idle();
    @(negedge clk);

    // Reset pulse in EXEC: transaction dropped, pointer back to NUM_REQ-1.
    set_req(0, 1'b1, 2'b10, 8'h0F, 8'h01);
    #1;
    wait_grant(w);
    check("rst_pre_grant", 32'(w), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    set_req(0, 1'b0, 2'b00, 8'h00, 8'h00);
    @(negedge clk);
    check("rst_mid_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_mid_rsp_data", 32'(bus.rsp_data), 32'd0);
    check("rst_mid_rsp_id", 32'(bus.rsp_id), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_req_ready", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    set_req(0, 1'b1, 2'b01, 8'h0F, 8'hF0);
    set_req(2, 1'b1, 2'b11, 8'h80, 8'h01);
    #1;
    wait_grant(w);
    check("rst_post_first_grant", 32'(w), 32'd0);
    if (w >= 0) push(w, (w == 0) ? 8'hFF : 8'h7F);
    @(posedge clk); #1;
    set_req(0, 1'b0, 2'b00, 8'h00, 8'h00);
    @(negedge clk);
    wait_grant(w);
    check("rst_post_second_grant", 32'(w), 32'd2);
    if (w >= 0) push(w, (w == 2) ? 8'h7F : 8'hFF);
    @(posedge clk); #1;
    set_req(2, 1'b0, 2'b00, 8'h00, 8'h00);
    wait_idle();
    @(negedge clk);

    // Withdrawn request: park the pointer on 0, serve 1, req3 drops, 0 is next.
    set_req(0, 1'b1, 2'b10, 8'h07, 8'h08);
    #1;
    wait_grant(w);
    if (w >= 0) push(0, 8'h0F);
    @(posedge clk); #1;
    set_req(0, 1'b0, 2'b00, 8'h00, 8'h00);
    wait_idle();
    @(negedge clk);
    set_req(1, 1'b1, 2'b00, 8'hF0, 8'h3C);
    set_req(3, 1'b1, 2'b10, 8'h01, 8'h01);
    #1;
    wait_grant(w);
    check("drop_first_grant", 32'(w), 32'd1);
    if (w >= 0) push(1, 8'h30);
    @(posedge clk); #1;
    set_req(1, 1'b0, 2'b00, 8'h00, 8'h00);
    set_req(3, 1'b0, 2'b00, 8'h00, 8'h00);
    set_req(0, 1'b1, 2'b01, 8'h01, 8'h02);
    @(negedge clk);
    wait_grant(w);
    check("drop_next_grant", 32'(w), 32'd0);
    if (w >= 0) push(0, 8'h03);
    @(posedge clk); #1;
    set_req(0, 1'b0, 2'b00, 8'h00, 8'h00);
    wait_idle();

    for (int n = 0; n < 20 && sb.size() != 0; n++) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
